// File: rtl/idma_pkg.sv
// Shared definitions for the iDMA command generators: FSM encoding,
// word size and default bus/counter widths.
package idma_pkg;

    localparam int IDMA_WORD_BYTES   = 32;
    localparam int IDMA_AXI_ADDR_WID = 32;
    localparam int IDMA_LINE_CNT_WID = 16;
    localparam int IDMA_BEAT_CNT_WID = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } idma_state_e;

endpackage

// File: rtl/idma_rd_cmd_gen_if.sv
// Read-channel request/beat interface between the command generator
// and the 256-bit read channel.
interface idma_rd_cmd_gen_if
    import idma_pkg::*;
#(
    parameter int AXI_ADDR_WID = IDMA_AXI_ADDR_WID
) ();

    logic                    rd_req;
    logic [AXI_ADDR_WID-1:0] rd_addr;
    logic [31:0]             rd_num;
    logic                    rd_addr_ready;
    logic                    beat_fire;

    modport master (
        output rd_req,
        output rd_addr,
        output rd_num,
        input  rd_addr_ready,
        input  beat_fire
    );

    modport slave (
        input  rd_req,
        input  rd_addr,
        input  rd_num,
        output rd_addr_ready,
        output beat_fire
    );

endinterface

// File: rtl/idma_beat_counter.sv
// Beat counter with loadable target; o_eq_next reports whether the count,
// including this cycle's increment, has reached the target.
module idma_beat_counter #(
    parameter int BEAT_CNT_WID = 32
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_clr,
    input  logic                    i_load,
    input  logic [BEAT_CNT_WID-1:0] i_total,
    input  logic                    i_inc,
    output logic                    o_eq_next
);

    logic [BEAT_CNT_WID-1:0] r_total;
    logic [BEAT_CNT_WID-1:0] r_count;
    logic [BEAT_CNT_WID-1:0] w_count_inc;

    assign w_count_inc = r_count + BEAT_CNT_WID'(i_inc);
    assign o_eq_next   = (w_count_inc == r_total);

    // Clear beats load, load beats increment.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_total <= '0;
            r_count <= '0;
        end else if (i_clr) begin
            r_total <= '0;
            r_count <= '0;
        end else if (i_load) begin
            r_total <= i_total;
            r_count <= '0;
        end else begin
            r_count <= w_count_inc;
        end
    end

endmodule

// File: rtl/idma_rd_cmd_gen.sv
// Expands a 2D strided read descriptor into one read request per line and
// signals completion once every requested beat has been consumed.
module idma_rd_cmd_gen
    import idma_pkg::*;
#(
    parameter int AXI_ADDR_WID = IDMA_AXI_ADDR_WID,
    parameter int LINE_CNT_WID = IDMA_LINE_CNT_WID,
    parameter int BEAT_CNT_WID = IDMA_BEAT_CNT_WID
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic                    cfg_start,
    input  logic                    cfg_abort,
    input  logic [AXI_ADDR_WID-1:0] cfg_base_addr,
    input  logic [LINE_CNT_WID-1:0] cfg_line_words,
    input  logic [AXI_ADDR_WID-1:0] cfg_line_stride,
    input  logic [LINE_CNT_WID-1:0] cfg_line_num,
    idma_rd_cmd_gen_if.master       rd_ch,
    output logic                    busy,
    output logic                    done,
    output logic                    err_cfg,
    output logic [LINE_CNT_WID-1:0] dbg_line_cnt
);

    idma_state_e             r_state;
    idma_state_e             w_state_nxt;
    logic [AXI_ADDR_WID-1:0] r_rd_addr;
    logic [AXI_ADDR_WID-1:0] r_stride;
    logic [31:0]             r_rd_num;
    logic [LINE_CNT_WID-1:0] r_line_num;
    logic [LINE_CNT_WID-1:0] r_line_cnt;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_err_cfg;

    logic                    w_rd_req;
    logic                    w_last_line;
    logic                    w_launch;
    logic                    w_reject;
    logic                    w_finish;
    logic                    w_beat_inc;
    logic                    w_beat_eq_next;
    logic [BEAT_CNT_WID-1:0] w_total;

    assign w_rd_req    = (r_state == ISSUE) && rd_ch.rd_addr_ready;
    assign w_last_line = (r_line_cnt == (r_line_num - LINE_CNT_WID'(1)));
    assign w_beat_inc  = rd_ch.beat_fire && (r_state != IDLE);
    assign w_total     = BEAT_CNT_WID'(cfg_line_words) * BEAT_CNT_WID'(cfg_line_num);

    idma_beat_counter #(
        .BEAT_CNT_WID(BEAT_CNT_WID)
    ) u_beat_cnt (
        .i_clk    (aclk),
        .i_rst_n  (aresetn),
        .i_clr    (cfg_abort),
        .i_load   (w_launch),
        .i_total  (w_total),
        .i_inc    (w_beat_inc),
        .o_eq_next(w_beat_eq_next)
    );

    // Abort overrides every other event, including the last push or beat.
    always_comb begin
        w_state_nxt = r_state;
        w_launch    = 1'b0;
        w_reject    = 1'b0;
        w_finish    = 1'b0;
        if (cfg_abort) begin
            w_state_nxt = IDLE;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (cfg_start) begin
                        if ((cfg_line_words == '0) || (cfg_line_num == '0)) begin
                            w_reject = 1'b1;
                        end else begin
                            w_launch    = 1'b1;
                            w_state_nxt = ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (w_rd_req && w_last_line) begin
                        w_state_nxt = DRAIN;
                    end
                end
                DRAIN: begin
                    if (w_beat_eq_next) begin
                        w_finish    = 1'b1;
                        w_state_nxt = IDLE;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_rd_addr  <= '0;
            r_stride   <= '0;
            r_rd_num   <= '0;
            r_line_num <= '0;
            r_line_cnt <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err_cfg  <= 1'b0;
        end else begin
            r_done    <= w_finish;
            r_err_cfg <= w_reject;
            if (cfg_abort) begin
                r_busy     <= 1'b0;
                r_line_cnt <= '0;
            end else if (w_launch) begin
                r_rd_addr  <= cfg_base_addr;
                r_stride   <= cfg_line_stride;
                r_rd_num   <= 32'(cfg_line_words);
                r_line_num <= cfg_line_num;
                r_line_cnt <= '0;
                r_busy     <= 1'b1;
            end else begin
                // Address wraps freely; 4K splitting happens in the channel.
                if (w_rd_req) begin
                    r_rd_addr  <= r_rd_addr + r_stride;
                    r_line_cnt <= r_line_cnt + LINE_CNT_WID'(1);
                end
                if (w_finish) begin
                    r_busy <= 1'b0;
                end
            end
        end
    end

    assign rd_ch.rd_req  = w_rd_req;
    assign rd_ch.rd_addr = r_rd_addr;
    assign rd_ch.rd_num  = r_rd_num;
    assign busy          = r_busy;
    assign done          = r_done;
    assign err_cfg       = r_err_cfg;
    assign dbg_line_cnt  = r_line_cnt;

endmodule

// File: tb/tb_idma_rd_cmd_gen.sv
// Self-checking bench for idma_rd_cmd_gen: directed scenarios plus random
// traffic, checked every cycle against a descriptor-level model.
module tb_idma_rd_cmd_gen;

    localparam int AW = 32;
    localparam int LW = 16;
    localparam int BW = 32;

    logic          aclk    = 1'b0;
    logic          aresetn = 1'b1;
    logic          cfg_start = 1'b0;
    logic          cfg_abort = 1'b0;
    logic [AW-1:0] cfg_base_addr = '0;
    logic [LW-1:0] cfg_line_words = '0;
    logic [AW-1:0] cfg_line_stride = '0;
    logic [LW-1:0] cfg_line_num = '0;
    logic          rdy = 1'b0;
    logic          bf  = 1'b0;
    logic          busy, done, err_cfg;
    logic [LW-1:0] dbg_line_cnt;

    idma_rd_cmd_gen_if #(.AXI_ADDR_WID(AW)) ch ();
    assign ch.rd_addr_ready = rdy;
    assign ch.beat_fire     = bf;

    idma_rd_cmd_gen #(
        .AXI_ADDR_WID(AW),
        .LINE_CNT_WID(LW),
        .BEAT_CNT_WID(BW)
    ) dut (
        .aclk           (aclk),
        .aresetn        (aresetn),
        .cfg_start      (cfg_start),
        .cfg_abort      (cfg_abort),
        .cfg_base_addr  (cfg_base_addr),
        .cfg_line_words (cfg_line_words),
        .cfg_line_stride(cfg_line_stride),
        .cfg_line_num   (cfg_line_num),
        .rd_ch          (ch),
        .busy           (busy),
        .done           (done),
        .err_cfg        (err_cfg),
        .dbg_line_cnt   (dbg_line_cnt)
    );

    always #5 aclk = ~aclk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Descriptor-level model: active flag, lines pushed so far, beats seen.
    bit          m_active = 0;
    int          m_pushed = 0;
    int          m_lines  = 0;
    int          m_words  = 0;
    int          m_beats  = 0;
    int          m_total  = 0;
    logic [31:0] m_base   = '0;
    logic [31:0] m_stride = '0;
    bit          m_done_q = 0;
    bit          m_err_q  = 0;

    logic [31:0] q_addr[$];
    logic [31:0] q_num[$];
    int          n_done_seen = 0;
    int          n_err_seen  = 0;

    bit          e_req;
    logic [31:0] e_addr;
    bit          n_done, n_err, was_drain;

    always @(negedge aclk) begin
        if (!aresetn) begin
            m_active = 0; m_pushed = 0; m_beats = 0; m_total = 0;
            m_done_q = 0; m_err_q = 0;
            chk("rst_rd_req", 64'(ch.rd_req), 64'd0);
            chk("rst_rd_addr", 64'(ch.rd_addr), 64'd0);
            chk("rst_rd_num", 64'(ch.rd_num), 64'd0);
            chk("rst_busy", 64'(busy), 64'd0);
            chk("rst_done", 64'(done), 64'd0);
            chk("rst_err", 64'(err_cfg), 64'd0);
            chk("rst_line_cnt", 64'(dbg_line_cnt), 64'd0);
        end else begin
            e_req = m_active && (m_pushed < m_lines) && rdy;
            chk("rd_req", 64'(ch.rd_req), 64'(e_req));
            if (e_req) begin
                e_addr = m_base + 32'(m_pushed) * m_stride;
                chk("rd_addr", 64'(ch.rd_addr), 64'(e_addr));
                chk("rd_num", 64'(ch.rd_num), 64'(m_words));
            end
            chk("busy", 64'(busy), 64'(m_active));
            chk("done", 64'(done), 64'(m_done_q));
            chk("err_cfg", 64'(err_cfg), 64'(m_err_q));
            chk("line_cnt", 64'(dbg_line_cnt), 64'(m_pushed));
            if (ch.rd_req) begin
                q_addr.push_back(ch.rd_addr);
                q_num.push_back(ch.rd_num);
            end
            if (done) n_done_seen++;
            if (err_cfg) n_err_seen++;

            n_done = 0;
            n_err  = 0;
            if (cfg_abort) begin
                m_active = 0; m_pushed = 0; m_beats = 0;
            end else if (!m_active) begin
                if (cfg_start) begin
                    if (cfg_line_words == 0 || cfg_line_num == 0) begin
                        n_err = 1;
                    end else begin
                        m_active = 1;
                        m_base   = cfg_base_addr;
                        m_stride = cfg_line_stride;
                        m_words  = int'(cfg_line_words);
                        m_lines  = int'(cfg_line_num);
                        m_total  = m_words * m_lines;
                        m_pushed = 0;
                        m_beats  = 0;
                    end
                end
            end else begin
                was_drain = (m_pushed == m_lines);
                if (bf) m_beats++;
                if (!was_drain && rdy) m_pushed++;
                if (was_drain && m_beats == m_total) begin
                    n_done   = 1;
                    m_active = 0;
                end
            end
            m_done_q = n_done;
            m_err_q  = n_err;
        end
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic launch(input logic [31:0] base, input int words,
                          input logic [31:0] stride, input int lines);
        cfg_base_addr   = base;
        cfg_line_words  = LW'(words);
        cfg_line_stride = stride;
        cfg_line_num    = LW'(lines);
        cfg_start       = 1'b1;
        tick();
        cfg_start       = 1'b0;
    endtask

    task automatic clear_log();
        q_addr.delete();
        q_num.delete();
        n_done_seen = 0;
        n_err_seen  = 0;
    endtask

    task automatic beats(input int n);
        bf = 1'b1;
        repeat (n) tick();
        bf = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit got;
        #1 aresetn = 1'b0;
        repeat (2) tick();
        aresetn = 1'b1;
        tick();

        // Basic 2D
        clear_log();
        rdy = 1'b1;
        launch(32'h1000_0000, 4, 32'h200, 3);
        repeat (3) tick();
        beats(12);
        repeat (2) tick();
        chk("basic_pushes", 64'(q_addr.size()), 64'd3);
        if (q_addr.size() == 3) begin
            chk("basic_a0", 64'(q_addr[0]), 64'h1000_0000);
            chk("basic_a1", 64'(q_addr[1]), 64'h1000_0200);
            chk("basic_a2", 64'(q_addr[2]), 64'h1000_0400);
            chk("basic_num", 64'(q_num[0]), 64'd4);
        end
        chk("basic_done_cnt", 64'(n_done_seen), 64'd1);
        chk("basic_busy_end", 64'(busy), 64'd0);

        // Backpressure
        clear_log();
        launch(32'h1000_0000, 4, 32'h200, 3);
        tick();
        rdy = 1'b0;
        repeat (5) begin
            tick();
            chk("bp_req", 64'(ch.rd_req), 64'd0);
            chk("bp_addr", 64'(ch.rd_addr), 64'h1000_0200);
            chk("bp_line_cnt", 64'(dbg_line_cnt), 64'd1);
        end
        rdy = 1'b1;
        repeat (2) tick();
        beats(12);
        repeat (2) tick();
        chk("bp_pushes", 64'(q_addr.size()), 64'd3);
        chk("bp_done_cnt", 64'(n_done_seen), 64'd1);

        // Zero-size descriptors
        clear_log();
        launch(32'h2000, 0, 32'h40, 3);
        chk("zw_err", 64'(err_cfg), 64'd1);
        chk("zw_busy", 64'(busy), 64'd0);
        tick();
        chk("zw_err_pulse", 64'(err_cfg), 64'd0);
        launch(32'h2000, 4, 32'h40, 0);
        chk("zl_err", 64'(err_cfg), 64'd1);
        repeat (2) tick();
        chk("zero_pushes", 64'(q_addr.size()), 64'd0);
        chk("zero_done", 64'(n_done_seen), 64'd0);
        chk("zero_err_cnt", 64'(n_err_seen), 64'd2);

        // Address wrap
        clear_log();
        launch(32'hFFFF_FF00, 1, 32'h100, 2);
        repeat (2) tick();
        beats(2);
        repeat (2) tick();
        chk("wrap_pushes", 64'(q_addr.size()), 64'd2);
        if (q_addr.size() == 2) begin
            chk("wrap_a0", 64'(q_addr[0]), 64'hFFFF_FF00);
            chk("wrap_a1", 64'(q_addr[1]), 64'h0000_0000);
        end
        chk("wrap_done", 64'(n_done_seen), 64'd1);

        // Abort after first push
        clear_log();
        launch(32'h3000, 2, 32'h80, 4);
        tick();
        rdy = 1'b0;
        cfg_abort = 1'b1;
        tick();
        cfg_abort = 1'b0;
        chk("ab1_busy", 64'(busy), 64'd0);
        chk("ab1_line_cnt", 64'(dbg_line_cnt), 64'd0);
        rdy = 1'b1;
        repeat (3) tick();
        chk("ab1_pushes", 64'(q_addr.size()), 64'd1);
        chk("ab1_no_done", 64'(n_done_seen), 64'd0);
        launch(32'h4000, 1, 32'h10, 1);
        tick();
        beats(1);
        repeat (2) tick();
        chk("ab1_restart_done", 64'(n_done_seen), 64'd1);
        if (q_addr.size() == 2) chk("ab1_restart_addr", 64'(q_addr[1]), 64'h4000);
        else chk("ab1_restart_pushes", 64'(q_addr.size()), 64'd2);

        // Abort together with the final beat
        clear_log();
        launch(32'h5000, 2, 32'h20, 2);
        repeat (2) tick();
        beats(3);
        bf = 1'b1;
        cfg_abort = 1'b1;
        tick();
        cfg_abort = 1'b0;
        bf = 1'b0;
        chk("ab2_busy", 64'(busy), 64'd0);
        chk("ab2_line_cnt", 64'(dbg_line_cnt), 64'd0);
        repeat (3) tick();
        chk("ab2_no_done", 64'(n_done_seen), 64'd0);
        launch(32'h6000, 1, 32'h0, 1);
        tick();
        beats(1);
        repeat (2) tick();
        chk("ab2_restart_done", 64'(n_done_seen), 64'd1);

        // Start and abort together while idle
        clear_log();
        cfg_abort = 1'b1;
        launch(32'h6100, 1, 32'h0, 1);
        cfg_abort = 1'b0;
        chk("sa_busy", 64'(busy), 64'd0);
        tick();
        chk("sa_pushes", 64'(q_addr.size()), 64'd0);

        // Start while busy, then back-to-back launch
        clear_log();
        launch(32'h7000, 1, 32'h100, 3);
        tick();
        cfg_base_addr = 32'h9000;
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        tick();
        chk("sb_pushes", 64'(q_addr.size()), 64'd3);
        if (q_addr.size() == 3) chk("sb_a2", 64'(q_addr[2]), 64'h7200);
        chk("sb_no_err", 64'(n_err_seen), 64'd0);
        bf = 1'b1;
        got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            tick();
            if (done) got = 1;
        end
        bf = 1'b0;
        chk("b2b_first_done", 64'(got), 64'd1);
        launch(32'h8000, 2, 32'h40, 1);
        chk("b2b_busy", 64'(busy), 64'd1);
        tick();
        beats(2);
        repeat (2) tick();
        chk("b2b_done_cnt", 64'(n_done_seen), 64'd2);
        if (q_addr.size() == 4) chk("b2b_addr", 64'(q_addr[3]), 64'h8000);
        else chk("b2b_pushes", 64'(q_addr.size()), 64'd4);

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            aresetn   = 1'b1;
            cfg_start = ($urandom % 8) == 0;
            cfg_abort = ($urandom % 80) == 0;
            if (cfg_start) begin
                cfg_base_addr   = $urandom;
                cfg_line_stride = $urandom;
                cfg_line_words  = LW'($urandom_range(0, 4));
                cfg_line_num    = LW'($urandom_range(0, 4));
            end
            rdy = ($urandom % 4) != 0;
            if (m_active) bf = (m_beats < m_pushed * m_words) && ($urandom % 2 == 1);
            else bf = ($urandom % 2) == 1;
            if ($urandom % 700 == 0) aresetn = 1'b0;
            tick();
        end
        aresetn   = 1'b1;
        cfg_start = 1'b0;
        cfg_abort = 1'b0;
        bf        = 1'b0;
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/idma_rd_cmd_gen.md
Name: idma_rd_cmd_gen

Overview:
- Upstream command generator for the iDMA 256-bit read channel.
- Expands one 2D strided read descriptor (base address, words per line, line stride, line count) into one read request per line on the channel's rd_req/rd_addr/rd_num interface.
- Counts accepted read-data beats and signals completion once every requested word has been consumed downstream.

Parameters:
AXI_ADDR_WID, 32, byte-address width of rd_addr, cfg_base_addr and cfg_line_stride
LINE_CNT_WID, 16, width of cfg_line_words, cfg_line_num and the internal line counter
BEAT_CNT_WID, 32, width of the total-beat product and the beat counter

Ports:
aclk  input  1  clock
aresetn  input  1  asynchronous active-low reset
cfg_start  input  1  single-cycle descriptor launch pulse
cfg_abort  input  1  single-cycle abort pulse
cfg_base_addr  input  AXI_ADDR_WID  byte address of line 0
cfg_line_words  input  LINE_CNT_WID  256-bit words per line
cfg_line_stride  input  AXI_ADDR_WID  byte distance between consecutive line starts
cfg_line_num  input  LINE_CNT_WID  number of lines
rd_addr_ready  input  1  channel address FIFO not full
beat_fire  input  1  rd_data_valid & rd_data_ready at the channel output
rd_req  output  1  push strobe into the channel address FIFO
rd_addr  output  AXI_ADDR_WID  line start address
rd_num  output  32  words in the line (zero-extended cfg_line_words)
busy  output  1  descriptor in progress
done  output  1  one-cycle completion pulse
err_cfg  output  1  one-cycle pulse: zero-size descriptor rejected
dbg_line_cnt  output  LINE_CNT_WID  lines issued for the current descriptor

Behaviour:
- Clock and reset: single clock aclk; reset aresetn is asynchronous, active-low.
- Reset values: state IDLE; rd_addr=0, rd_num=0, busy=0, done=0, err_cfg=0, dbg_line_cnt=0, beat counter=0, total=0. rd_req is 0 because the state is IDLE.
- FSM states: IDLE, ISSUE, DRAIN.
- IDLE, on cfg_start:
  - If cfg_line_words==0 or cfg_line_num==0: err_cfg=1 for the next cycle, stay in IDLE, no done.
  - Otherwise register rd_addr=cfg_base_addr, rd_num=cfg_line_words, stride, line_num, and total=cfg_line_words*cfg_line_num (unsigned product, BEAT_CNT_WID bits). Clear the counters and go to ISSUE. busy=1 from the next cycle.
- ISSUE:
  - rd_req = (state==ISSUE) & rd_addr_ready. This is combinational, with no extra latency, and is the only push qualifier.
  - Each cycle with rd_req=1: rd_addr <= rd_addr + stride (wraps mod 2^AXI_ADDR_WID, no 4K check; splitting is the channel's job) and dbg_line_cnt++.
  - When rd_req=1 and dbg_line_cnt==line_num-1, go to DRAIN. rd_addr still advances, and its value is don't-care after the last push.
  - rd_addr_ready=0 stalls issue; address and count are held.
- Beat counting: beat_fire increments the beat counter in ISSUE and DRAIN. It is ignored in IDLE.
- DRAIN: rd_req=0. When the beat counter equals total (including the cycle the last beat_fire arrives, evaluated on the next-state count): done=1 for one cycle, busy=0, and the FSM returns to IDLE in the same transition.
- cfg_start while busy is ignored and produces no error.
- cfg_abort in any state: next cycle IDLE, busy=0, counters cleared, no done. Abort has priority over every other event in the same cycle, including the last push and the last beat. Requests already pushed stay in the channel FIFO; software must pulse rd_afifo_init/rd_dfifo_init.
- cfg_start and cfg_abort in the same cycle while IDLE: abort wins, no launch.
- Back-to-back operation: done and a new cfg_start in the next cycle is legal.
- Reset mid-operation returns all state to the reset values immediately.

Decomposition:
- Shared package idma_pkg holds:
  - the FSM state encoding (IDLE=2'd0, ISSUE=2'd1, DRAIN=2'd2);
  - the constant IDMA_WORD_BYTES=32;
  - the default widths (AXI_ADDR_WID=32, LINE_CNT_WID=16).
- One sub-module is natural: idma_beat_counter. It holds the total/beat compare, with load, increment, clear and equal-next outputs, and is reusable on the write side.

Test Plan:
- Basic 2D: base=0x1000_0000, words=4, stride=0x200, lines=3, rd_addr_ready=1 -> rd_req on 3 consecutive cycles with addresses 0x1000_0000/0x1000_0200/0x1000_0400 and rd_num=4. After 12 beat_fire pulses, done pulses once and busy falls the same cycle.
- Backpressure: same descriptor, rd_addr_ready low for 5 cycles after the first push -> no rd_req while low, address held at 0x1000_0200, and exactly 3 pushes total.
- Zero-size: lines=0 or words=0 -> err_cfg pulses one cycle, busy stays 0, no rd_req, no done.
- Address wrap: base=0xFFFF_FF00, stride=0x100, lines=2 -> addresses 0xFFFF_FF00 then 0x0000_0000.
- Abort: abort after 1 push of a 4-line descriptor, and separately abort in the same cycle as the final beat_fire -> IDLE next cycle, no done, dbg_line_cnt=0, and a new start is accepted normally.
- Start while busy plus back-to-back: a second cfg_start during ISSUE is ignored (push count is unchanged). A start issued the cycle after done launches cleanly with the beat counter reset.
